// File: rtl/matrix_result_streamer.sv
// Captures a flat DIM x DIM element matrix on start and streams it out one element
// per valid/ready handshake, in row-major or column-major (transposed) order.
module matrix_result_streamer #(
  parameter  int DIM    = 5,
  parameter  int ELEM_W = 8,
  localparam int MAT_W  = DIM * DIM * ELEM_W,
  localparam int IDX_W  = $clog2(DIM * DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              col_major,
  input  logic [MAT_W-1:0]  C_flat,
  input  logic              overflow_in,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf_latched
);

  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] LAST_RC  = CNT_W'(DIM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM * DIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q;
  logic [MAT_W-1:0]   buf_q;
  logic               col_major_q;
  logic [CNT_W-1:0]   row_q;
  logic [CNT_W-1:0]   col_q;

  logic [CNT_W-1:0]   row_nx;
  logic [CNT_W-1:0]   col_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic [IDX_W-1:0]   elem_sel;
  logic [ELEM_W-1:0]  data_nx;
  logic               xfer;

  assign xfer = out_valid & out_ready;

  // Next read position: the inner counter is col for row-major, row for column-major.
  always_comb begin
    row_nx = row_q;
    col_nx = col_q;
    if (col_major_q) begin
      if (row_q == LAST_RC) begin
        row_nx = '0;
        col_nx = col_q + 1'b1;
      end else begin
        row_nx = row_q + 1'b1;
      end
    end else begin
      if (col_q == LAST_RC) begin
        col_nx = '0;
        row_nx = row_q + 1'b1;
      end else begin
        col_nx = col_q + 1'b1;
      end
    end
    idx_nx   = out_idx + 1'b1;
    elem_sel = IDX_W'(row_nx) * IDX_W'(DIM) + IDX_W'(col_nx);
    data_nx  = buf_q[int'(elem_sel) * ELEM_W +: ELEM_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      col_major_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf_latched <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            buf_q       <= C_flat;
            col_major_q <= col_major;
            ovf_latched <= overflow_in;
            row_q       <= '0;
            col_q       <= '0;
            out_data    <= C_flat[ELEM_W-1:0];
            out_idx     <= '0;
            out_last    <= (LAST_IDX == '0);
            out_valid   <= 1'b1;
            busy        <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_q   <= DONE;
            end else begin
              row_q    <= row_nx;
              col_q    <= col_nx;
              out_idx  <= idx_nx;
              out_data <= data_nx;
              out_last <= (idx_nx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer: a stimulus process queues expected
// elements from a plain-arithmetic matrix model, a monitor pops them on each transfer.
module tb_matrix_result_streamer;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int NEL    = DIM * DIM;
  localparam int MAT_W  = NEL * ELEM_W;
  localparam int IDX_W  = $clog2(NEL);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              col_major;
  logic [MAT_W-1:0]  C_flat;
  logic              overflow_in;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              ovf_latched;

  matrix_result_streamer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .col_major(col_major),
    .C_flat(C_flat), .overflow_in(overflow_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .ovf_latched(ovf_latched)
  );

  typedef struct {
    logic [ELEM_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t              sb_q[$];
  logic [ELEM_W-1:0] mat[NEL];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                xfer_cnt = 0;
  int                done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake seen before a rising edge is one element transfer.
  initial begin
    exp_t              e;
    logic              prev_v = 1'b0;
    logic              prev_r = 1'b0;
    logic [ELEM_W-1:0] prev_d = '0;
    logic [IDX_W-1:0]  prev_i = '0;
    logic              prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r && out_valid) begin
          check("hold_data", out_data, prev_d);
          check("hold_idx", out_idx, prev_i);
          check("hold_last", out_last, prev_l);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_xfer_idx", out_idx, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check("xfer_data", out_data, e.data);
            check("xfer_idx", out_idx, e.idx);
            check("xfer_last", out_last, e.last);
          end
          xfer_cnt++;
        end
        if (done) done_cnt++;
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
        prev_i = out_idx;
        prev_l = out_last;
      end
    end
  end

  function automatic logic [MAT_W-1:0] random_flat();
    logic [MAT_W-1:0] f;
    for (int k = 0; k < NEL; k++) f[k*ELEM_W +: ELEM_W] = ELEM_W'($urandom_range(0, 255));
    return f;
  endfunction

  task automatic load_matrix(input bit sequential);
    for (int k = 0; k < NEL; k++)
      mat[k] = sequential ? ELEM_W'(k + 1) : ELEM_W'($urandom_range(0, 255));
  endtask

  // Reference order: k-th element is (k/DIM, k%DIM) or its transpose.
  task automatic push_expected(input bit colm);
    exp_t e;
    int   r, c;
    for (int k = 0; k < NEL; k++) begin
      r = colm ? (k % DIM) : (k / DIM);
      c = colm ? (k / DIM) : (k % DIM);
      e.data = mat[r * DIM + c];
      e.idx  = IDX_W'(k);
      e.last = (k == NEL - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_stream(input bit colm, input bit ovf);
    for (int k = 0; k < NEL; k++) C_flat[k*ELEM_W +: ELEM_W] = mat[k];
    col_major   = colm;
    overflow_in = ovf;
    start       = 1'b1;
    push_expected(colm);
    xfer_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start       = 1'b0;
    C_flat      = random_flat();
    overflow_in = ~ovf;
    col_major   = ~colm;
    check("first_valid", out_valid, 1);
    check("first_busy", busy, 1);
    check("first_idx", out_idx, 0);
    check("first_data", out_data, mat[0]);
    check("ovf_captured", ovf_latched, ovf);
  endtask

  // mode 0: ready held high, 1: 1,0,0,1 repeating, 2: random
  task automatic finish_stream(input int mode, input bit ovf, input bit mid_start, input int exp_edges);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mid_start && cyc == 5) begin
        start       = 1'b1;
        C_flat      = random_flat();
        col_major   = 1'b1;
        overflow_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (exp_edges > 0) check("done_latency", cyc, exp_edges);
    check("busy_at_done", busy, 0);
    check("valid_at_done", out_valid, 0);
    check("xfer_count", xfer_cnt, NEL);
    check("sb_empty", sb_q.size(), 0);
    check("ovf_at_done", ovf_latched, ovf);
    @(posedge clk); #1;
    check("done_pulse_count", done_cnt, 1);
    check("done_cleared", done, 0);
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, ovf_latched, 0);
  endtask

  initial begin
    int  wait_cyc;
    bit  colm;
    bit  ovf;
    rst_n       = 1'b0;
    start       = 1'b0;
    col_major   = 1'b0;
    C_flat      = '0;
    overflow_in = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_matrix(1'b1);
    start_stream(1'b0, 1'b0);
    finish_stream(0, 1'b0, 1'b0, NEL);

    start_stream(1'b1, 1'b0);
    finish_stream(0, 1'b0, 1'b0, NEL);

    start_stream(1'b0, 1'b0);
    finish_stream(1, 1'b0, 1'b0, -1);

    start_stream(1'b0, 1'b0);
    finish_stream(0, 1'b0, 1'b1, NEL);

    // Asynchronous reset in the middle of a stream, away from any clock edge.
    load_matrix(1'b0);
    start_stream(1'b0, 1'b1);
    out_ready = 1'b1;
    wait_cyc  = 0;
    while (xfer_cnt < 10 && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("reached_10_xfers", (xfer_cnt >= 10), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb_q.delete();
    @(posedge clk); #1;
    check_all_zero("held_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_matrix(1'b0);
    start_stream(1'b1, 1'b0);
    finish_stream(0, 1'b0, 1'b0, NEL);

    load_matrix(1'b0);
    start_stream(1'b0, 1'b1);
    finish_stream(2, 1'b1, 1'b0, -1);
    load_matrix(1'b0);
    start_stream(1'b1, 1'b0);
    finish_stream(0, 1'b0, 1'b0, NEL);

    for (int t = 0; t < 8; t++) begin
      load_matrix(1'b0);
      colm = 1'($urandom_range(0, 1));
      ovf  = 1'($urandom_range(0, 1));
      start_stream(colm, ovf);
      finish_stream(2, ovf, (t % 3 == 1), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
